alarm_clock_ctrl: RTL and testbench

ALARM_CLOCK_CTRL -- requirements
Module: alarm_clock_ctrl

---
 rtl/clock_pkg.sv | 28 ++
 rtl/ring_timer.sv | 39 +++
 rtl/alarm_clock_ctrl.sv | 112 +++++++++++
 tb/tb_alarm_clock_ctrl.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared constants for the alarm clock: mode encodings, counter limits and the mode sequencer.
package clock_pkg;

   localparam logic [2:0] MODE_NORMAL  = 3'd0;
   localparam logic [2:0] MODE_SET_MIN = 3'd1;
   localparam logic [2:0] MODE_SET_HR  = 3'd2;
   localparam logic [2:0] MODE_ALM_MIN = 3'd3;
   localparam logic [2:0] MODE_ALM_HR  = 3'd4;

   localparam int SEC_MAX = 59;
   localparam int MIN_MAX = 59;
   localparam int HR_MAX  = 23;

   // Cyclic order NORMAL -> SET_MIN -> SET_HR -> ALM_MIN -> ALM_HR -> NORMAL.
   function automatic logic [2:0] next_mode(input logic [2:0] m);
      logic [2:0] n;
      n = MODE_NORMAL;
      case (m)
         MODE_NORMAL:  n = MODE_SET_MIN;
         MODE_SET_MIN: n = MODE_SET_HR;
         MODE_SET_HR:  n = MODE_ALM_MIN;
         MODE_ALM_MIN: n = MODE_ALM_HR;
         default:      n = MODE_NORMAL;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/ring_timer.sv
// Counts tick_1hz pulses while the alarm rings and ends the ring after RING_TICKS ticks.
module ring_timer #(
   parameter int RING_TICKS = 60
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   input  logic stop,
   input  logic tick,
   output logic done,
   output logic active
);

   localparam int CNT_W = $clog2(RING_TICKS + 1);

   logic [CNT_W-1:0] cnt;

   // The start tick itself is not counted; counting begins with the following tick.
   assign done = active && tick && !start && !stop && (cnt == CNT_W'(RING_TICKS - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         active <= 1'b0;
         cnt    <= '0;
      end else if (stop) begin
         active <= 1'b0;
         cnt    <= '0;
      end else if (start) begin
         active <= 1'b1;
         cnt    <= '0;
      end else if (done) begin
         active <= 1'b0;
         cnt    <= '0;
      end else if (active && tick) begin
         cnt    <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/alarm_clock_ctrl.sv
// Alarm clock controller: mode sequencing, counter enable/direction decode, arming and ringing.
module alarm_clock_ctrl
   import clock_pkg::*;
#(
   parameter int RING_TICKS = 60,
   parameter int SEC_W      = 6,
   parameter int HR_W       = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             tick_1hz,
   input  logic             btn_mode,
   input  logic             btn_up,
   input  logic             btn_down,
   input  logic             btn_alarm,
   input  logic [SEC_W-1:0] sec,
   input  logic [SEC_W-1:0] min,
   input  logic [SEC_W-1:0] amin,
   input  logic [HR_W-1:0]  hr,
   input  logic [HR_W-1:0]  ahr,
   output logic             sec_en,
   output logic             min_en,
   output logic             hr_en,
   output logic             amin_en,
   output logic             ahr_en,
   output logic             up_down,
   output logic [2:0]       mode,
   output logic             armed,
   output logic             ringing
);

   logic btn_any;
   logic consume;
   logic in_set;
   logic timekeep;
   logic set_req;
   logic btn_eff;
   logic sec_wrap;
   logic min_wrap;
   logic alarm_match;
   logic ring_start;
   logic ring_stop;
   logic ring_done;

   assign btn_any  = btn_mode | btn_up | btn_down | btn_alarm;
   // While ringing, any button only silences the alarm.
   assign consume  = ringing && btn_any;
   assign in_set   = (mode == MODE_SET_MIN) || (mode == MODE_SET_HR);
   assign timekeep = tick_1hz && !in_set;
   assign sec_wrap = (sec == SEC_W'(SEC_MAX));
   assign min_wrap = (min == SEC_W'(MIN_MAX));

   assign set_req  = !consume && !btn_mode && (mode != MODE_NORMAL) && (btn_up ^ btn_down);
   // A coincident tick forces up-counting, so a down press in an alarm mode is dropped.
   assign btn_eff  = set_req && !(timekeep && btn_down);

   assign alarm_match = (hr == ahr) && (min == amin) && sec_wrap;
   assign ring_start  = tick_1hz && armed && !in_set && alarm_match && !ringing;
   assign ring_stop   = ringing && (btn_any || !armed);

   always_comb begin
      sec_en  = 1'b0;
      min_en  = 1'b0;
      hr_en   = 1'b0;
      amin_en = 1'b0;
      ahr_en  = 1'b0;
      up_down = 1'b1;
      if (!reset) begin
         if (timekeep) begin
            sec_en = 1'b1;
            min_en = sec_wrap;
            hr_en  = sec_wrap && min_wrap;
         end
         if (btn_eff) begin
            up_down = btn_up;
            case (mode)
               MODE_SET_MIN: min_en  = 1'b1;
               MODE_SET_HR:  hr_en   = 1'b1;
               MODE_ALM_MIN: amin_en = 1'b1;
               MODE_ALM_HR:  ahr_en  = 1'b1;
               default:      ;
            endcase
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mode  <= MODE_NORMAL;
         armed <= 1'b0;
      end else if (!consume) begin
         if (btn_mode) begin
            mode <= next_mode(mode);
         end else if (btn_alarm) begin
            armed <= !armed;
         end
      end
   end

   ring_timer #(
      .RING_TICKS(RING_TICKS)
   ) u_ring_timer (
      .clk    (clk),
      .reset  (reset),
      .start  (ring_start),
      .stop   (ring_stop),
      .tick   (tick_1hz),
      .done   (ring_done),
      .active (ringing)
   );

endmodule

// File: tb/tb_alarm_clock_ctrl.sv
// Directed-vector bench for alarm_clock_ctrl with hand-computed expectations.
module tb_alarm_clock_ctrl;

   logic       clk;
   logic       reset;
   logic       tick_1hz, btn_mode, btn_up, btn_down, btn_alarm;
   logic [5:0] sec, min, amin;
   logic [4:0] hr, ahr;
   logic       sec_en, min_en, hr_en, amin_en, ahr_en, up_down;
   logic [2:0] mode;
   logic       armed, ringing;
   logic [4:0] en;

   int nvec = 0;
   int nmis = 0;

   alarm_clock_ctrl #(.RING_TICKS(60), .SEC_W(6), .HR_W(5)) dut (
      .clk(clk), .reset(reset), .tick_1hz(tick_1hz),
      .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down), .btn_alarm(btn_alarm),
      .sec(sec), .min(min), .amin(amin), .hr(hr), .ahr(ahr),
      .sec_en(sec_en), .min_en(min_en), .hr_en(hr_en), .amin_en(amin_en), .ahr_en(ahr_en),
      .up_down(up_down), .mode(mode), .armed(armed), .ringing(ringing)
   );

   assign en = {sec_en, min_en, hr_en, amin_en, ahr_en};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nmis++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Apply one cycle of inputs at the falling edge; combinational outputs are valid 1 ns later.
   task automatic drive(input logic t, input logic m, input logic u, input logic d, input logic a);
      @(negedge clk);
      tick_1hz = t; btn_mode = m; btn_up = u; btn_down = d; btn_alarm = a;
      #1;
   endtask

   task automatic edge_done();
      @(posedge clk);
      #1;
      tick_1hz = 0; btn_mode = 0; btn_up = 0; btn_down = 0; btn_alarm = 0;
   endtask

   task automatic cycle(input logic t, input logic m, input logic u, input logic d, input logic a);
      drive(t, m, u, d, a);
      edge_done();
   endtask

   initial begin
      reset = 1;
      tick_1hz = 0; btn_mode = 0; btn_up = 0; btn_down = 0; btn_alarm = 0;
      sec = 0; min = 0; amin = 0; hr = 0; ahr = 0;

      // Reset state, enables held low even with a tick present
      sec = 59; min = 59;
      drive(1, 0, 0, 0, 0);
      chk("rst_en", 32'(en), 32'h00);
      edge_done();
      chk("rst_mode", 32'(mode), 32'd0);
      chk("rst_armed", 32'(armed), 32'd0);
      chk("rst_ring", 32'(ringing), 32'd0);
      @(negedge clk); reset = 0;

      // Timekeeping rollover in NORMAL
      sec = 59; min = 59; hr = 5;
      drive(1, 0, 0, 0, 0);
      chk("norm_roll_en", 32'(en), 32'b11100);
      chk("norm_roll_ud", 32'(up_down), 32'd1);
      edge_done();
      sec = 30; min = 0; hr = 0;
      drive(1, 0, 0, 0, 0);
      chk("norm_tick_en", 32'(en), 32'b10000);
      edge_done();
      drive(0, 0, 1, 0, 0);
      chk("norm_up_en", 32'(en), 32'b00000);
      edge_done();
      chk("norm_up_mode", 32'(mode), 32'd0);

      // Step through all modes into ALM_HR
      sec = 0;
      for (int i = 1; i <= 4; i++) begin
         cycle(0, 1, 0, 0, 0);
         chk($sformatf("mode_step%0d", i), 32'(mode), 32'(i));
      end
      ahr = 0;
      drive(0, 0, 0, 1, 0);
      chk("almhr_dn_en", 32'(en), 32'b00001);
      chk("almhr_dn_ud", 32'(up_down), 32'd0);
      edge_done();
      drive(1, 0, 0, 1, 0);
      chk("almhr_tick_dn_en", 32'(en), 32'b10000);
      chk("almhr_tick_dn_ud", 32'(up_down), 32'd1);
      edge_done();
      drive(1, 0, 1, 0, 0);
      chk("almhr_tick_up_en", 32'(en), 32'b10001);
      chk("almhr_tick_up_ud", 32'(up_down), 32'd1);
      edge_done();
      cycle(0, 1, 0, 0, 0);
      chk("mode_wrap", 32'(mode), 32'd0);

      // SET_MIN: seconds frozen, conflicting buttons ignored
      cycle(0, 1, 0, 0, 0);
      chk("setmin_mode", 32'(mode), 32'd1);
      sec = 30;
      drive(1, 0, 0, 0, 0);
      chk("setmin_tick_en", 32'(en), 32'b00000);
      edge_done();
      sec = 59; min = 59;
      drive(1, 0, 0, 0, 0);
      chk("setmin_tick59_en", 32'(en), 32'b00000);
      edge_done();
      sec = 0; min = 0;
      drive(0, 0, 1, 1, 0);
      chk("setmin_updn_en", 32'(en), 32'b00000);
      edge_done();
      drive(0, 0, 1, 0, 0);
      chk("setmin_up_en", 32'(en), 32'b01000);
      chk("setmin_up_ud", 32'(up_down), 32'd1);
      edge_done();
      drive(0, 0, 0, 1, 0);
      chk("setmin_dn_en", 32'(en), 32'b01000);
      chk("setmin_dn_ud", 32'(up_down), 32'd0);
      edge_done();
      drive(0, 1, 1, 0, 0);
      chk("mode_plus_up_en", 32'(en), 32'b00000);
      edge_done();
      chk("mode_plus_up_mode", 32'(mode), 32'd2);

      // Asynchronous reset while in SET_HR
      @(negedge clk);
      reset = 1;
      #1;
      chk("async_rst_mode", 32'(mode), 32'd0);
      @(negedge clk); reset = 0;
      drive(0, 0, 0, 0, 0);
      chk("rst_release_en", 32'(en), 32'b00000);
      edge_done();

      // Arm, match and ring for 60 ticks
      cycle(0, 0, 0, 0, 1);
      chk("armed_on", 32'(armed), 32'd1);
      amin = 10; min = 10; ahr = 7; hr = 7; sec = 59;
      cycle(1, 0, 0, 0, 0);
      chk("ring_start", 32'(ringing), 32'd1);
      sec = 0;
      for (int i = 1; i <= 59; i++) begin
         cycle(1, 0, 0, 0, 0);
      end
      chk("ring_tick59", 32'(ringing), 32'd1);
      cycle(1, 0, 0, 0, 0);
      chk("ring_tick60", 32'(ringing), 32'd0);

      // Retrigger, then silence with btn_mode
      sec = 59;
      cycle(1, 0, 0, 0, 0);
      chk("ring_restart", 32'(ringing), 32'd1);
      sec = 0;
      drive(0, 1, 0, 0, 0);
      chk("ring_btn_en", 32'(en), 32'b00000);
      edge_done();
      chk("ring_btn_stop", 32'(ringing), 32'd0);
      chk("ring_btn_mode", 32'(mode), 32'd0);
      chk("ring_btn_armed", 32'(armed), 32'd1);

      // No ringing from a SET mode
      cycle(0, 1, 0, 0, 0);
      sec = 59;
      cycle(1, 0, 0, 0, 0);
      chk("setmin_no_ring", 32'(ringing), 32'd0);
      sec = 0;
      cycle(0, 0, 0, 0, 1);
      chk("armed_off", 32'(armed), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
